pulse_filter_sched: RTL and testbench
=====================================

# pulse_filter_sched

Round-robin sampling scheduler that shares one majority-vote filter datapath across NCH asynchronous input lines, such as IR receivers or wake pins. A programmable prescaler produces a sample tick. On each tick the block scans the channels in turn, one per clock. Each channel has its own 3-bit history and produces a filtered level plus single-cycle rise and fall events. It sits between the raw pads and the peripheral logic that consumes debounced levels.

## Interface
- NCH, 4, number of channels (2..16)
- PRESC_W, 16, prescaler width in bits
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- clear_n  input  1  synchronous clear, active low; same effect as reset
- cfg_enable  input  1  1 = prescaler runs and ticks are generated
- cfg_prescaler  input  PRESC_W  tick period minus 1, in clk cycles
- i_raw  input  NCH  raw asynchronous inputs
- o_value  output  NCH  filtered level per channel
- o_rise  output  NCH  one-cycle pulse when o_value[k] goes 0->1
- o_fall  output  NCH  one-cycle pulse when o_value[k] goes 1->0
- o_tick  output  1  one-cycle pulse for each accepted sample tick
- o_busy  output  1  1 while a scan is in progress
- o_overrun  output  1  one-cycle pulse when a tick is dropped because a scan is still running

## Operation
- Synchronizer: each i_raw bit passes through 2 flops, giving sync[k]. Flops reset to 0.
- Prescaler:
  - Counter cnt resets to 0.
  - When cfg_enable=1: if cnt==cfg_prescaler, set cnt to 0 and raise the internal tick; otherwise increment cnt.
  - When cfg_enable=0: cnt is held at 0 and no ticks occur.
  - Compare is done against the live cfg_prescaler. If cfg_prescaler is lowered below cnt, cnt counts up and wraps modulo 2^PRESC_W.
- FSM with states IDLE and SCAN, plus channel index ch of width ceil(log2 NCH):
  - IDLE: on tick, set o_tick=1 for one cycle, go to SCAN, ch=0.
  - SCAN, each cycle:
    - hist[ch] <= {sync[ch], hist[ch][2:1]}
    - new = maj3(sync[ch], hist[ch][2], hist[ch][1])
    - o_value[ch] <= new
    - o_rise[ch] <= new & ~o_value[ch]; o_fall[ch] <= ~new & o_value[ch]
    - if ch==NCH-1, go to IDLE; otherwise ch++
  - Only one channel updates per cycle. All other rise and fall bits are 0.
- Tick while in SCAN: the tick is dropped, o_overrun pulses, and the scan continues unchanged. No tick is queued.
- o_busy = (state==SCAN).
- cfg_enable falling during SCAN: the current scan completes, and no further ticks occur.
- clear_n=0: the same registers are cleared as by rst_n, in the next cycle, and this takes priority over all other activity. A scan in progress is aborted.
- Reset values: o_value=0, o_rise=0, o_fall=0, o_tick=0, o_busy=0, o_overrun=0, all hist=0, cnt=0, state IDLE, ch=0.

## Timing
- Tick period is cfg_prescaler+1 cycles. cfg_prescaler=0 ticks every cycle while enabled.
- Overrun-free operation requires cfg_prescaler >= NCH. Otherwise every tick arriving in SCAN is dropped.
- Let o_tick be high in cycle T:
  - SCAN runs in cycles T+1 .. T+NCH.
  - Channel k is sampled in cycle T+1+k.
  - o_value[k], o_rise[k] and o_fall[k] update at the start of cycle T+2+k.
  - o_busy is high in T+1 .. T+NCH.
- Input to sample latency is 2 synchronizer cycles before the sampling cycle.
- Filter response, starting from a steady level, is 2 consecutive agreeing samples. A single-sample glitch never changes o_value.
- Rise, fall and tick are strictly single-cycle. Rise and fall are mutually exclusive per channel.

## Test plan
- Reset/idle: assert rst_n=0 mid-scan with NCH=4, then release -> all outputs 0 and state IDLE. The first o_tick comes cfg_prescaler+1 cycles after enable.
- Basic filter: cfg_prescaler=7, hold i_raw[1]=1 -> o_value[1] rises after the 2nd tick's ch1 slot, with o_rise[1] pulsing once. Other channels stay 0.
- Glitch reject: i_raw[0]=1 for exactly one sample slot (8-cycle window), otherwise 0 -> o_value[0] stays 0 and no rise or fall.
- Fall: after o_value[2]=1, drive i_raw[2]=0 -> o_fall[2] pulses on the 2nd subsequent tick, and o_value[2]=0 from then on.
- Overrun: cfg_prescaler=2 with NCH=4 -> o_overrun pulses on every tick that lands in SCAN and the scan length stays 4 cycles. Accepted ticks occur every 6 cycles, and channel values still update correctly.
- Clear/disable: set cfg_enable=0 during ch1 -> scan completes through ch3 and no more o_tick. Then pulse clear_n=0 with o_value=4'b1111 -> next cycle o_value=0 with no o_fall pulses.

Source files
------------

// File: rtl/pulse_filter_sched.sv
// pulse_filter_sched
// Round-robin sampler that shares one majority-vote filter across NCH
// asynchronous input lines. A prescaler generates sample ticks, and each
// accepted tick starts a scan that visits one channel per clock.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear_n           synchronous active-low clear (same effect as reset)
//   cfg_enable        run the prescaler and generate ticks
//   cfg_prescaler     tick period minus one, in clk cycles
//   i_raw[NCH]        raw asynchronous inputs
//   o_value[NCH]      filtered level per channel
//   o_rise/o_fall     single-cycle edge events of o_value
//   o_tick            accepted sample tick
//   o_busy            scan in progress
//   o_overrun         tick dropped because a scan was still running
//
// state  | meaning
// S_IDLE | waiting for a prescaler tick
// S_SCAN | sampling channel r_ch, one channel per cycle

module pulse_filter_sched #(
  parameter int NCH     = 4,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_n,
  input  logic               cfg_enable,
  input  logic [PRESC_W-1:0] cfg_prescaler,
  input  logic [NCH-1:0]     i_raw,
  output logic [NCH-1:0]     o_value,
  output logic [NCH-1:0]     o_rise,
  output logic [NCH-1:0]     o_fall,
  output logic               o_tick,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int CH_W = $clog2(NCH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_ch, w_ch_nxt;
  logic [NCH-1:0]      r_sync1, r_sync2;
  logic [PRESC_W-1:0]  r_cnt;
  // Only the two previous samples feed the vote; the oldest history bit
  // would be shifted out unread, so it is not kept.
  logic [2:1]          r_hist [NCH];
  logic [NCH-1:0]      r_value, r_rise, r_fall;
  logic                w_tick, w_scan, w_sample, w_new;

  // Clear suppresses the tick so nothing else happens in the clear cycle.
  assign w_tick   = cfg_enable & clear_n & (r_cnt == cfg_prescaler);
  assign w_scan   = (r_state == S_SCAN);
  assign w_sample = r_sync2[r_ch];
  assign w_new    = (w_sample & r_hist[r_ch][2]) |
                    (w_sample & r_hist[r_ch][1]) |
                    (r_hist[r_ch][2] & r_hist[r_ch][1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
    end else if (!clear_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    o_tick      = 1'b0;
    o_overrun   = 1'b0;
    o_busy      = w_scan;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          o_tick      = 1'b1;
          w_state_nxt = S_SCAN;
          w_ch_nxt    = '0;
        end
      end
      S_SCAN: begin
        // A tick during a scan is dropped, never queued.
        o_overrun = w_tick;
        if (r_ch == LAST_CH) begin
          w_state_nxt = S_IDLE;
          w_ch_nxt    = '0;
        end else begin
          w_ch_nxt = r_ch + CH_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ch_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
      r_value <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int k = 0; k < NCH; k++) r_hist[k] <= '0;
    end else if (!clear_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
      r_value <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int k = 0; k < NCH; k++) r_hist[k] <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Equality compare against the live setting: lowering it below the
      // count lets the counter run on and wrap.
      if (!cfg_enable || (r_cnt == cfg_prescaler)) r_cnt <= '0;
      else                                          r_cnt <= r_cnt + PRESC_W'(1);
      r_rise <= '0;
      r_fall <= '0;
      if (w_scan) begin
        r_hist[r_ch]  <= {w_sample, r_hist[r_ch][2]};
        r_value[r_ch] <= w_new;
        r_rise[r_ch]  <= w_new & ~r_value[r_ch];
        r_fall[r_ch]  <= ~w_new & r_value[r_ch];
      end
    end
  end

  assign o_value = r_value;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: tb/tb_pulse_filter_sched.sv
// Directed bench for pulse_filter_sched (NCH=4): a table of per-tick input
// patterns with hand-computed filter results, plus hand-written sequences
// for reset, first-tick timing, overrun, disable and clear.

module tb_pulse_filter_sched;

  localparam int NCH = 4;
  localparam int PW  = 16;

  logic            clk = 1'b0;
  logic            rst_n, clear_n, cfg_enable;
  logic [PW-1:0]   cfg_prescaler;
  logic [NCH-1:0]  i_raw, o_value, o_rise, o_fall;
  logic            o_tick, o_busy, o_overrun;

  always #5 clk = ~clk;

  pulse_filter_sched #(.NCH(NCH), .PRESC_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .clear_n(clear_n), .cfg_enable(cfg_enable),
    .cfg_prescaler(cfg_prescaler), .i_raw(i_raw), .o_value(o_value),
    .o_rise(o_rise), .o_fall(o_fall), .o_tick(o_tick), .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] val;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs [11];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   excl_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of negedges waited until o_tick is seen, -1 on timeout.
  task automatic wait_tick(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (o_tick) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_tick: no o_tick within %0d cycles", budget);
    end
  endtask

  // One table row: apply raw, wait for the tick, watch the 6 following cycles.
  task automatic run_row(input vec_t v, input int idx);
    int w, pulses, ticks;
    logic [3:0] rise_or, fall_or;
    logic [6:0] busy_v;
    i_raw = v.raw;
    wait_tick(40, w);
    rise_or = '0; fall_or = '0; pulses = 0; ticks = 0; busy_v = '0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      busy_v[j] = o_busy;
      ticks    += int'(o_tick);
      rise_or  |= o_rise;
      fall_or  |= o_fall;
      pulses   += $countones(o_rise) + $countones(o_fall);
      if ((o_rise & o_fall) != 0) excl_err++;
      for (int k = 0; k < NCH; k++)
        if (o_rise[k] | o_fall[k])
          check($sformatf("row%0d_slot_ch%0d", idx, k), j, k + 2);
    end
    check($sformatf("row%0d_value", idx), o_value, v.val);
    check($sformatf("row%0d_rise", idx), rise_or, v.rise);
    check($sformatf("row%0d_fall", idx), fall_or, v.fall);
    check($sformatf("row%0d_pulses", idx), pulses, $countones(v.rise) + $countones(v.fall));
    check($sformatf("row%0d_busy", idx), busy_v, 7'b0011110);
    check($sformatf("row%0d_no_tick", idx), ticks, 0);
  endtask

  initial begin
    int w, fall_n, rise_n;
    logic [20:0] tick_v, ovr_v, busy_v, exp_tick, exp_ovr, exp_busy;
    logic [9:0]  busy_d, tick_d;

    //            raw      value    rise     fall
    vecs[0]  = '{4'b0110, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0111, 4'b0110, 4'b0110, 4'b0000};  // ch0 glitch, ch1/ch2 rise
    vecs[2]  = '{4'b0110, 4'b0110, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b1010, 4'b0110, 4'b0000, 4'b0000};  // ch2 first low sample
    vecs[4]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0100};  // ch2 falls on 2nd
    vecs[5]  = '{4'b1011, 4'b1010, 4'b1000, 4'b0000};  // ch3 1,0,1 votes high
    vecs[6]  = '{4'b0001, 4'b0011, 4'b0001, 4'b1000};
    vecs[7]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0010};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};
    vecs[10] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};

    rst_n = 1'b0; clear_n = 1'b1; cfg_enable = 1'b0; cfg_prescaler = 16'd7; i_raw = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_value, o_rise, o_fall, o_tick, o_busy, o_overrun}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {o_value, o_rise, o_fall, o_tick, o_busy, o_overrun}, 0);

    // Enable raised in cycle E: count 0..7 gives the tick in E+7 (8th cycle).
    cfg_enable = 1'b1;
    wait_tick(50, w);
    check("first_tick_delay", w, 7);
    @(negedge clk);
    check("busy_t1", o_busy, 1);
    @(negedge clk);
    check("busy_t2", o_busy, 1);
    rst_n = 1'b0; cfg_enable = 1'b0;
    #1;
    check("reset_mid_scan", {o_value, o_rise, o_fall, o_tick, o_busy, o_overrun}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", {o_busy, o_value}, 0);

    cfg_enable = 1'b1;
    for (int r = 0; r < 11; r++) run_row(vecs[r], r);

    // Overrun: prescaler 2 -> ticks every 3 cycles, scans of 4 cycles.
    i_raw = '0; cfg_enable = 1'b0;
    @(negedge clk);
    cfg_prescaler = 16'd2; cfg_enable = 1'b1;
    wait_tick(20, w);
    check("ovr_first_tick", w, 2);
    tick_v = '0; ovr_v = '0; busy_v = '0; fall_n = 0; rise_n = 0;
    tick_v[0] = o_tick; ovr_v[0] = o_overrun; busy_v[0] = o_busy;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      tick_v[j] = o_tick; ovr_v[j] = o_overrun; busy_v[j] = o_busy;
      fall_n += $countones(o_fall);
      rise_n += $countones(o_rise);
      if ((o_rise & o_fall) != 0) excl_err++;
    end
    exp_tick = '0; exp_ovr = '0; exp_busy = '0;
    for (int j = 0; j <= 20; j++) begin
      exp_tick[j] = (j % 6 == 0);
      exp_ovr[j]  = (j % 6 == 3);
      exp_busy[j] = (j % 6 >= 1) && (j % 6 <= 4);
    end
    check("ovr_ticks", tick_v, exp_tick);
    check("ovr_overruns", ovr_v, exp_ovr);
    check("ovr_busy", busy_v, exp_busy);
    check("ovr_fall_count", fall_n, 4);
    check("ovr_rise_count", rise_n, 0);
    check("ovr_value", o_value, 4'b0000);

    // Cycle j=20 samples ch1 of the scan started at j=18; disable here.
    cfg_enable = 1'b0;
    busy_d = '0; tick_d = '0;
    for (int j = 21; j <= 30; j++) begin
      @(negedge clk);
      busy_d[j-21] = o_busy;
      tick_d[j-21] = o_tick | o_overrun;
    end
    check("disable_scan_completes", busy_d, 10'b0000000011);
    check("disable_no_ticks", tick_d, 10'b0);

    // Fill all channels high, then clear mid-scan of the third tick.
    cfg_prescaler = 16'd7; i_raw = 4'b1111; cfg_enable = 1'b1;
    wait_tick(20, w);
    wait_tick(20, w);
    wait_tick(20, w);
    @(negedge clk);
    @(negedge clk);
    check("pre_clear_value", o_value, 4'b1111);
    check("pre_clear_busy", o_busy, 1);
    clear_n = 1'b0;
    @(negedge clk);
    check("clear_value", o_value, 4'b0000);
    check("clear_no_fall", o_fall, 4'b0000);
    check("clear_aborts_scan", {o_busy, o_rise, o_tick}, 0);
    clear_n = 1'b1;
    fall_n = 0;
    repeat (5) begin
      @(negedge clk);
      fall_n += $countones(o_fall);
    end
    check("post_clear_no_fall", fall_n, 0);
    check("rise_fall_exclusive", excl_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
